ir_chunk_loader: RTL and testbench

- Parametrised successor to the fixed 16-bit half-loaded instruction register.
- Holds an IR_WIDTH-bit instruction register and fills it from a narrow BUS_WIDTH memory bus, one chunk per valid/ready handshake, under a small fill state machine.
- Keeps the clear/load/decrement/increment function-select semantics and adds a wrap flag.
- Sits between the memory data bus and the control unit's decoder.

---
 rtl/ir_pkg.sv | 26 ++
 rtl/ir_chunk_loader_if.sv | 12 +
 rtl/ir_lane_writer.sv | 23 ++
 rtl/ir_chunk_loader.sv | 109 ++++++++++
 tb/tb_ir_chunk_loader.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ir_pkg.sv
// Shared definitions for the chunk-loaded instruction register:
// function-select encodings, fill-state enum and a width helper.
package ir_pkg;

  localparam logic [1:0] FS_CLR  = 2'b00;
  localparam logic [1:0] FS_LOAD = 2'b01;
  localparam logic [1:0] FS_DEC  = 2'b10;
  localparam logic [1:0] FS_INC  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_e;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ir_chunk_loader_if.sv
// Narrow memory-bus handshake feeding the instruction register:
// one BUS_WIDTH chunk per valid/ready transfer.
interface ir_chunk_loader_if #(
  parameter int BUS_WIDTH = 8
);
  logic [BUS_WIDTH-1:0] i_chunk;
  logic                 i_valid;
  logic                 i_ready;

  modport master (output i_chunk, output i_valid, input i_ready);
  modport slave  (input i_chunk, input i_valid, output i_ready);
endinterface

// File: rtl/ir_lane_writer.sv
// Maps the current chunk index to a one-hot lane write-enable, honouring
// the chunk arrival order (LSB-first or MSB-first).
module ir_lane_writer #(
  parameter int NCHUNK     = 2,
  parameter int HIGH_FIRST = 0,
  parameter int IDX_W      = 1
) (
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  chunk_idx,
  output logic [NCHUNK-1:0] lane_we
);

  // Select the destination lane of the chunk being accepted this cycle.
  always_comb begin
    // NOTE: default first so every path assigns lane_we and no latch is inferred.
    lane_we = '0;
    for (int j = 0; j < NCHUNK; j++) begin
      if (HIGH_FIRST != 0) lane_we[j] = wr_en && (int'(chunk_idx) == NCHUNK - 1 - j);
      else                 lane_we[j] = wr_en && (int'(chunk_idx) == j);
    end
  end

endmodule

// File: rtl/ir_chunk_loader.sv
// Parametrised instruction register filled chunk-by-chunk from a narrow
// memory bus, with clear/load/decrement/increment function select and a
// wrap-around pulse. Sits between the memory data bus and the decoder.
module ir_chunk_loader
  import ir_pkg::*;
#(
  parameter int IR_WIDTH   = 16,
  parameter int BUS_WIDTH  = 8,
  parameter int HIGH_FIRST = 0
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   e,
  input  logic [1:0]                             funsel,
  input  logic                                   abort,
  ir_chunk_loader_if.slave                       bus,
  output logic [IR_WIDTH-1:0]                    ir_out,
  output logic                                   ir_valid,
  output logic                                   busy,
  output logic [clog2(IR_WIDTH/BUS_WIDTH)-1:0]   chunk_idx,
  output logic                                   wrap
);

  localparam int NCHUNK = IR_WIDTH / BUS_WIDTH;
  localparam int IDX_W  = clog2(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  // A register narrower than two chunks, or not a whole number of chunks,
  // has no meaningful fill sequence.
  if (NCHUNK < 2 || NCHUNK * BUS_WIDTH != IR_WIDTH) begin : g_bad_params
    $error("ir_chunk_loader: IR_WIDTH must be a multiple (>=2) of BUS_WIDTH");
  end

  fill_state_e       state;
  logic [NCHUNK-1:0] lane_we;
  logic              handshake;

  assign busy        = (state == FILL);
  assign bus.i_ready = (state == FILL) && e && !abort;
  assign handshake   = bus.i_valid && bus.i_ready;

  ir_lane_writer #(
    .NCHUNK     (NCHUNK),
    .HIGH_FIRST (HIGH_FIRST),
    .IDX_W      (IDX_W)
  ) u_lane_writer (
    .wr_en     (handshake),
    .chunk_idx (chunk_idx),
    .lane_we   (lane_we)
  );

  // Fill FSM, chunk counter, lane capture and clear/inc/dec in one register block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ir_out    <= '0;
      ir_valid  <= 1'b0;
      chunk_idx <= '0;
      wrap      <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register sees pre-edge values.
      wrap <= 1'b0;
      if (e) begin
        case (state)
          FILL: begin
            if (abort) begin
              state     <= IDLE;
              chunk_idx <= '0;
            end else if (bus.i_valid) begin
              for (int j = 0; j < NCHUNK; j++) begin
                if (lane_we[j]) ir_out[j*BUS_WIDTH +: BUS_WIDTH] <= bus.i_chunk;
              end
              if (chunk_idx == LAST_IDX) begin
                state     <= DONE;
                ir_valid  <= 1'b1;
                chunk_idx <= '0;
              end else begin
                chunk_idx <= chunk_idx + IDX_W'(1);
              end
            end
          end
          default: begin
            case (funsel)
              FS_CLR: begin
                ir_out   <= '0;
                ir_valid <= 1'b0;
                state    <= IDLE;
              end
              FS_LOAD: begin
                state     <= FILL;
                chunk_idx <= '0;
                ir_valid  <= 1'b0;
              end
              FS_DEC: begin
                ir_out <= ir_out - IR_WIDTH'(1);
                wrap   <= (ir_out == '0);
              end
              default: begin
                ir_out <= ir_out + IR_WIDTH'(1);
                wrap   <= (ir_out == '1);
              end
            endcase
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_chunk_loader.sv
// Scoreboard bench for ir_chunk_loader: a 16/8 LSB-first instance and a
// 32/8 MSB-first instance, one active at a time. The driver advances a
// behavioural model and queues expectations; the monitor compares.
module tb_ir_chunk_loader;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       e      = 1'b0;
  logic       abort  = 1'b0;
  logic       valid  = 1'b0;
  logic [1:0] funsel = 2'b00;
  logic [7:0] chunk  = 8'h00;
  bit         sel    = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  ir_chunk_loader_if #(.BUS_WIDTH(8)) bus_a ();
  ir_chunk_loader_if #(.BUS_WIDTH(8)) bus_b ();
  assign bus_a.i_chunk = chunk;
  assign bus_a.i_valid = valid;
  assign bus_b.i_chunk = chunk;
  assign bus_b.i_valid = valid;

  logic [15:0] a_ir;
  logic        a_valid, a_busy, a_wrap;
  logic [0:0]  a_idx;
  logic [31:0] b_ir;
  logic        b_valid, b_busy, b_wrap;
  logic [1:0]  b_idx;

  ir_chunk_loader #(.IR_WIDTH(16), .BUS_WIDTH(8), .HIGH_FIRST(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .e(e && !sel), .funsel(funsel), .abort(abort),
    .bus(bus_a), .ir_out(a_ir), .ir_valid(a_valid), .busy(a_busy),
    .chunk_idx(a_idx), .wrap(a_wrap)
  );

  ir_chunk_loader #(.IR_WIDTH(32), .BUS_WIDTH(8), .HIGH_FIRST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .e(e && sel), .funsel(funsel), .abort(abort),
    .bus(bus_b), .ir_out(b_ir), .ir_valid(b_valid), .busy(b_busy),
    .chunk_idx(b_idx), .wrap(b_wrap)
  );

  logic [31:0] s_ir;
  logic        s_valid, s_busy, s_wrap, s_ready;
  int          s_idx;
  always_comb begin
    if (sel) begin
      s_ir = b_ir; s_valid = b_valid; s_busy = b_busy; s_wrap = b_wrap;
      s_idx = int'(b_idx); s_ready = bus_b.i_ready;
    end else begin
      s_ir = {16'h0, a_ir}; s_valid = a_valid; s_busy = a_busy; s_wrap = a_wrap;
      s_idx = int'(a_idx); s_ready = bus_a.i_ready;
    end
  end

  // Behavioural model: register value, completeness, fill progress.
  int     m_w, m_n;
  bit     m_hf;
  longint m_ir;
  bit     m_valid, m_fill, m_wrap;
  int     m_k;

  typedef struct {
    logic [31:0] ir;
    bit          valid, busy, wrap, ready, chk_ready;
    int          idx;
  } exp_t;
  exp_t q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ir = 0; m_valid = 0; m_fill = 0; m_wrap = 0; m_k = 0;
  endfunction

  function automatic exp_t snapshot();
    exp_t x;
    x.ir = 32'(m_ir); x.valid = m_valid; x.busy = m_fill; x.wrap = m_wrap;
    x.idx = m_k; x.ready = 1'b0; x.chk_ready = 1'b0;
    return x;
  endfunction

  // One clock cycle of stimulus; the model predicts the state after the edge.
  task automatic cyc(input bit r, input bit ee, input logic [1:0] fs, input bit ab,
                     input bit vv, input logic [7:0] ch);
    exp_t   x;
    bit     rdy;
    longint mask;
    int     lane;
    @(negedge clk);
    rst_n = r; e = ee; funsel = fs; abort = ab; valid = vv; chunk = ch;
    mask = (longint'(1) << m_w) - 1;
    if (!r) model_reset();
    rdy    = m_fill && ee && !ab;
    m_wrap = 0;
    if (r && ee) begin
      if (m_fill) begin
        if (ab) begin
          m_fill = 0; m_k = 0;
        end else if (vv) begin
          lane = m_hf ? (m_n - 1 - m_k) : m_k;
          m_ir = (m_ir & ~(longint'(8'hff) << (lane * 8))) | (longint'(ch) << (lane * 8));
          m_k++;
          if (m_k == m_n) begin
            m_fill = 0; m_valid = 1; m_k = 0;
          end
        end
      end else begin
        case (fs)
          2'b00: begin m_ir = 0; m_valid = 0; end
          2'b01: begin m_fill = 1; m_k = 0; m_valid = 0; end
          2'b10: begin m_wrap = (m_ir == 0);    m_ir = (m_ir - 1) & mask; end
          default: begin m_wrap = (m_ir == mask); m_ir = (m_ir + 1) & mask; end
        endcase
      end
    end
    x = snapshot();
    x.ready = rdy; x.chk_ready = 1'b1;
    q.push_back(x);
  endtask

  task automatic idle();
    cyc(1, 0, 2'b00, 0, 0, 8'h00);
  endtask

  task automatic load16(input logic [15:0] v);
    cyc(1, 1, 2'b01, 0, 0, 8'h00);
    cyc(1, 1, 2'b00, 0, 1, v[7:0]);
    cyc(1, 1, 2'b00, 0, 1, v[15:8]);
  endtask

  // Asynchronous reset asserted between edges, checked immediately.
  task automatic reset_mid();
    exp_t x;
    @(negedge clk);
    e = 1; valid = 0; abort = 0; funsel = 2'b00;
    #3 rst_n = 1'b0;
    #1;
    check("async_ir", s_ir, 32'h0);
    check("async_valid", 32'(s_valid), 32'h0);
    check("async_busy", 32'(s_busy), 32'h0);
    check("async_idx", 32'(s_idx), 32'h0);
    check("async_wrap", 32'(s_wrap), 32'h0);
    check("async_ready", 32'(s_ready), 32'h0);
    model_reset();
    x = snapshot();
    q.push_back(x);
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1, $urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)),
          $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 8'($urandom));
    end
  endtask

  // Monitor: samples i_ready mid-cycle and registers after each edge.
  initial begin
    bit   rdy;
    exp_t x;
    forever begin
      @(negedge clk);
      #2 rdy = s_ready;
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        check("ir_out", s_ir, x.ir);
        check("ir_valid", 32'(s_valid), 32'(x.valid));
        check("busy", 32'(s_busy), 32'(x.busy));
        check("chunk_idx", 32'(s_idx), 32'(x.idx));
        check("wrap", 32'(s_wrap), 32'(x.wrap));
        if (x.chk_ready) check("i_ready", 32'(rdy), 32'(x.ready));
      end
    end
  end

  initial begin
    m_w = 16; m_n = 2; m_hf = 0;
    model_reset();
    cyc(0, 0, 2'b00, 0, 0, 8'h00);
    cyc(0, 0, 2'b00, 0, 0, 8'h00);

    // Basic LSB-first load
    load16(16'h33aa);
    idle();

    // Increment / decrement with wrap
    load16(16'hfffe);
    repeat (3) cyc(1, 1, 2'b11, 0, 0, 8'h00);
    repeat (2) cyc(1, 1, 2'b10, 0, 0, 8'h00);
    idle();

    // Abort keeps written lanes, then clear
    load16(16'h4c4c);
    cyc(1, 1, 2'b01, 0, 0, 8'h00);
    cyc(1, 1, 2'b00, 0, 1, 8'h55);
    cyc(1, 1, 2'b00, 1, 1, 8'h99);
    cyc(1, 1, 2'b00, 0, 0, 8'h00);

    // Stall with e low, async reset mid-fill, then a clean load
    cyc(1, 1, 2'b01, 0, 0, 8'h00);
    cyc(1, 0, 2'b00, 0, 1, 8'h77);
    cyc(1, 1, 2'b00, 0, 1, 8'h12);
    reset_mid();
    cyc(1, 0, 2'b00, 0, 0, 8'h00);
    load16(16'hbeef);

    // funsel ignored while busy; reload after DONE clears ir_valid
    cyc(1, 1, 2'b01, 0, 0, 8'h00);
    cyc(1, 1, 2'b00, 0, 1, 8'h21);
    cyc(1, 1, 2'b11, 0, 0, 8'h00);
    cyc(1, 1, 2'b00, 0, 1, 8'h43);
    cyc(1, 1, 2'b01, 0, 0, 8'h00);
    cyc(1, 1, 2'b00, 0, 1, 8'h65);
    cyc(1, 1, 2'b00, 0, 1, 8'h87);

    random_run(250);
    cyc(1, 0, 2'b00, 0, 0, 8'h00);
    @(posedge clk);
    #2;

    // Switch to the 32-bit MSB-first instance (idle and reset-state since time 0)
    sel = 1'b1;
    m_w = 32; m_n = 4; m_hf = 1;
    model_reset();
    cyc(1, 1, 2'b01, 0, 0, 8'h00);
    cyc(1, 1, 2'b00, 0, 1, 8'h01);
    cyc(1, 1, 2'b00, 0, 0, 8'hee);
    cyc(1, 1, 2'b00, 0, 1, 8'h23);
    cyc(1, 1, 2'b00, 0, 1, 8'h45);
    cyc(1, 1, 2'b00, 0, 0, 8'hdd);
    cyc(1, 1, 2'b00, 0, 1, 8'h67);
    idle();
    random_run(250);
    idle();

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
